// File: rtl/mul_unit_pkg.sv
// Shared pipeline definitions for the Execute-stage iterative multiplier.
// Holds the multiplier FSM states, the M-extension multiply funct3 encodings
// and the ResultSrc code that selects the multiplier leg of the writeback mux.
package mul_unit_pkg;

  localparam int unsigned XLEN = 32;

  // Shared with the decoder and the writeback mux.
  localparam logic [2:0] RESULT_SRC_MUL = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } mul_state_t;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011
  } mul_op_t;

  // rs1 is signed for MUL, MULH and MULHSU.
  function automatic logic op_a_signed(logic [2:0] funct3);
    return funct3 != 3'b011;
  endfunction

  // rs2 is signed for MUL and MULH only.
  function automatic logic op_b_signed(logic [2:0] funct3);
    return funct3[2:1] == 2'b00;
  endfunction

endpackage

// File: rtl/mul_sign_adjust.sv
// Conditional two's complement: passes the value through, or negates it when
// negate_i is set. Used for operand magnitudes and for the final product sign.
module mul_sign_adjust #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             negate_i,
  output logic [WIDTH-1:0] value_o
);

  // Negate by invert-and-increment when requested.
  always_comb begin
    value_o = negate_i ? (~value_i + WIDTH'(1)) : value_i;
  end

endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU in the Execute stage.
// Works on operand magnitudes, one multiplier bit per cycle, and applies the
// product sign at the end. busy stalls the pipeline while the unit runs.
// Optional feature: define MUL_EARLY_OUT_EN to leave RUN as soon as the
// remaining multiplier bits are all zero (results are unchanged).
module mul_unit
  import mul_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mul_state_t          state_q, state_d;
  mul_op_t             op_q, op_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [4:0]          count_q, count_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_neg, b_neg;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [2*XLEN-1:0]   acc_sum;
  logic [XLEN-1:0]     mplier_shift;
  logic [2*XLEN-1:0]   prod;
  logic                last_step;
  logic                accept;

  assign a_neg = op_a_signed(funct3) & a[XLEN-1];
  assign b_neg = op_b_signed(funct3) & b[XLEN-1];

  mul_sign_adjust #(
    .WIDTH(XLEN)
  ) u_mag_a (
    .value_i  (a),
    .negate_i (a_neg),
    .value_o  (mag_a)
  );

  mul_sign_adjust #(
    .WIDTH(XLEN)
  ) u_mag_b (
    .value_i  (b),
    .negate_i (b_neg),
    .value_o  (mag_b)
  );

  // Product of the current step, sign-corrected, so the result can be
  // registered on the same edge that enters DONE.
  mul_sign_adjust #(
    .WIDTH(2 * XLEN)
  ) u_prod (
    .value_i  (acc_sum),
    .negate_i (neg_q),
    .value_o  (prod)
  );

  // One shift-add step of the datapath and the RUN exit condition.
  always_comb begin
    acc_sum      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_shift = mplier_q >> 1;
`ifdef MUL_EARLY_OUT_EN
    last_step    = (count_q == 5'd31) || (mplier_shift == '0);
`else
    last_step    = (count_q == 5'd31);
`endif
  end

  assign accept = (state_q == StIdle) && start && !flush;

  // Next-state and datapath updates; everything holds unless changed below.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (funct3[2]) begin
            // Unsupported encoding: complete immediately with zero.
            state_d  = StDone;
            result_d = '0;
          end else begin
            state_d  = StRun;
            op_d     = mul_op_t'(funct3);
            neg_d    = a_neg ^ b_neg;
            mcand_d  = {{XLEN{1'b0}}, mag_a};
            mplier_d = mag_b;
            acc_d    = '0;
            count_d  = '0;
          end
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_shift;
          count_d  = count_q + 5'd1;
          if (last_step) begin
            state_d  = StDone;
            result_d = (op_q == OpMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  // Stall request and completion pulse; a flush in DONE suppresses the pulse.
  always_comb begin
    busy   = !reset && (accept || (state_q == StRun));
    done   = !reset && !flush && (state_q == StDone);
    result = result_q;
  end

endmodule
